// File: rtl/vec_realign_pkg.sv
// vec_realign shared types: FSM state encoding and width helpers.
// Imported by vec_realign and used for SUB_IDX_WIDTH sizing.
package vec_realign_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Index width for the sub-words of the widest vector, never below 1.
  function automatic int sub_idx_w(input int max_w, input int bus_w);
    int n;
    n = ceil_div(max_w, bus_w);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_lshift.sv
// vec_lshift: zero-filling left shift of a 2*W accumulator by 0..W.
// Ports: din (2*W), amt (0..W), dout (2*W).
module vec_lshift #(
  parameter int W  = 128,
  parameter int SW = $clog2(W + 1)
) (
  input  logic [2*W-1:0] din,
  input  logic [SW-1:0]  amt,
  output logic [2*W-1:0] dout
);

  assign dout = din << amt;

endmodule

// File: rtl/vec_realign.sv
// vec_realign: splits a packed MSB-first vector stream into per-vector,
// MSB-aligned, zero-padded bus words with ready/valid on both sides.
// Ports: clk, rst (async, active-high); cfg_VecWidth; up_Vector/up_Valid/
// up_Last/up_Ready; dn_Vector/dn_VecID/dn_SubIdx/dn_VecLast/dn_Last/
// dn_Valid/dn_Ready; err_CfgZero (pulse when width 0 was latched).
module vec_realign
  import vec_realign_pkg::*;
#(
  parameter int BUS_WIDTH     = 128,
  parameter int MAX_VEC_WIDTH = 920,
  parameter int VEC_ID_WIDTH  = 8,
  parameter int SUB_IDX_WIDTH = sub_idx_w(MAX_VEC_WIDTH, BUS_WIDTH),
  parameter int CFG_WIDTH     = $clog2(MAX_VEC_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CFG_WIDTH-1:0]     cfg_VecWidth,
  input  logic [BUS_WIDTH-1:0]     up_Vector,
  input  logic                     up_Valid,
  input  logic                     up_Last,
  output logic                     up_Ready,
  output logic [BUS_WIDTH-1:0]     dn_Vector,
  output logic [VEC_ID_WIDTH-1:0]  dn_VecID,
  output logic [SUB_IDX_WIDTH-1:0] dn_SubIdx,
  output logic                     dn_VecLast,
  output logic                     dn_Last,
  output logic                     dn_Valid,
  input  logic                     dn_Ready,
  output logic                     err_CfgZero
);

  localparam int AW = 2 * BUS_WIDTH;
  localparam int FW = $clog2(AW + 1);
  localparam int TW = $clog2(BUS_WIDTH + 1);

  localparam logic [FW-1:0] BUS_F =
    FW'(BUS_WIDTH);
  localparam logic [CFG_WIDTH-1:0] BUS_C =
    CFG_WIDTH'(BUS_WIDTH);
  localparam logic [CFG_WIDTH-1:0] MAX_C =
    CFG_WIDTH'(MAX_VEC_WIDTH);

  fsm_e                     r_State;
  logic [AW-1:0]            r_Acc;
  logic [FW-1:0]            r_Fill;
  logic [CFG_WIDTH-1:0]     r_Rem;
  logic [CFG_WIDTH-1:0]     r_Width;
  logic                     r_LastSeen;
  logic [VEC_ID_WIDTH-1:0]  r_VecId;
  logic [SUB_IDX_WIDTH-1:0] r_SubIdx;
  logic                     r_ErrZero;

  logic [TW-1:0]        take;
  logic [FW-1:0]        take_f;
  logic [FW-1:0]        fill_left;
  logic [FW-1:0]        fill_base;
  logic                 vec_end;
  logic                 batch_end;
  logic                 accept;
  logic                 emit;
  logic [CFG_WIDTH-1:0] cfg_eff;
  logic [TW-1:0]        shift_amt;
  logic [TW-1:0]        align_amt;
  logic [AW-1:0]        acc_shift;
  logic [AW-1:0]        word_pos;
  logic [AW-1:0]        acc_next;
  logic [BUS_WIDTH-1:0] keep_mask;

  assign take = (r_Rem > BUS_C) ?
    TW'(BUS_WIDTH) : TW'(r_Rem);
  assign take_f    = FW'(take);
  assign fill_left = r_Fill - take_f;

  assign dn_Valid = (r_State != ST_IDLE) &&
                    (r_Fill >= take_f);
  assign vec_end  = (CFG_WIDTH'(take) == r_Rem);

  // Once up_Last is in, a leftover shorter than one
  // vector can only be stream padding.
  assign batch_end = vec_end && r_LastSeen &&
    (CFG_WIDTH'(fill_left) < r_Width);

  assign keep_mask  = ~({BUS_WIDTH{1'b1}} >> take);
  assign dn_Vector  = r_Acc[AW-1 -: BUS_WIDTH] & keep_mask;
  assign dn_VecLast = dn_Valid && vec_end;
  assign dn_Last    = dn_Valid && batch_end;
  assign dn_VecID   = r_VecId;
  assign dn_SubIdx  = r_SubIdx;
  assign err_CfgZero = r_ErrZero;

  assign up_Ready = !r_LastSeen && (r_Fill <= BUS_F);
  assign accept   = up_Valid && up_Ready;
  assign emit     = dn_Valid && dn_Ready;

  assign cfg_eff = (cfg_VecWidth == '0) ?
    MAX_C : cfg_VecWidth;

  // Consume first, then place the new word right
  // below whatever valid bits remain.
  assign shift_amt = emit ? take : '0;
  assign fill_base = emit ? fill_left : r_Fill;
  assign align_amt = TW'(BUS_F - fill_base);

  vec_lshift #(
    .W (BUS_WIDTH),
    .SW(TW)
  ) u_consume (
    .din (r_Acc),
    .amt (shift_amt),
    .dout(acc_shift)
  );

  vec_lshift #(
    .W (BUS_WIDTH),
    .SW(TW)
  ) u_align (
    .din (AW'(up_Vector)),
    .amt (align_amt),
    .dout(word_pos)
  );

  assign acc_next = acc_shift |
    (accept ? word_pos : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_State    <= ST_IDLE;
      r_Acc      <= '0;
      r_Fill     <= '0;
      r_Rem      <= '0;
      r_Width    <= '0;
      r_LastSeen <= 1'b0;
      r_VecId    <= '0;
      r_SubIdx   <= '0;
      r_ErrZero  <= 1'b0;
    end else begin
      r_ErrZero <= 1'b0;
      if (emit && batch_end) begin
        r_State    <= ST_IDLE;
        r_Acc      <= '0;
        r_Fill     <= '0;
        r_Rem      <= r_Width;
        r_LastSeen <= 1'b0;
        r_VecId    <= '0;
        r_SubIdx   <= '0;
      end else begin
        if (emit || accept)
          r_Acc <= acc_next;
        r_Fill <= fill_base +
          (accept ? BUS_F : '0);
        if (emit) begin
          if (vec_end) begin
            r_Rem    <= r_Width;
            r_SubIdx <= '0;
            r_VecId  <= r_VecId +
              VEC_ID_WIDTH'(1);
          end else begin
            r_Rem    <= r_Rem -
              CFG_WIDTH'(take);
            r_SubIdx <= r_SubIdx +
              SUB_IDX_WIDTH'(1);
          end
        end
        if (accept) begin
          if (r_State == ST_IDLE) begin
            r_Width   <= cfg_eff;
            r_Rem     <= cfg_eff;
            r_ErrZero <= (cfg_VecWidth == '0);
          end
          if (up_Last) begin
            r_LastSeen <= 1'b1;
            r_State    <= ST_DRAIN;
          end else if (r_State == ST_IDLE) begin
            r_State <= ST_RUN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_realign.sv
// tb_vec_realign: random batches checked against a bit-level stream model.
// Drives vec_realign at BUS_WIDTH=128, MAX_VEC_WIDTH=920.
module tb_vec_realign;

  typedef struct {
    logic [127:0] vec;
    int           id;
    int           sub;
    bit           vl;
    bit           last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [9:0]   cfg_VecWidth;
  logic [127:0] up_Vector;
  logic         up_Valid;
  logic         up_Last;
  logic         up_Ready;
  logic [127:0] dn_Vector;
  logic [7:0]   dn_VecID;
  logic [2:0]   dn_SubIdx;
  logic         dn_VecLast;
  logic         dn_Last;
  logic         dn_Valid;
  logic         dn_Ready;
  logic         err_CfgZero;

  int checks;
  int failures;

  exp_t         exp_q[$];
  logic [127:0] wq[$];

  vec_realign dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_VecWidth(cfg_VecWidth),
    .up_Vector   (up_Vector),
    .up_Valid    (up_Valid),
    .up_Last     (up_Last),
    .up_Ready    (up_Ready),
    .dn_Vector   (dn_Vector),
    .dn_VecID    (dn_VecID),
    .dn_SubIdx   (dn_SubIdx),
    .dn_VecLast  (dn_VecLast),
    .dn_Last     (dn_Last),
    .dn_Valid    (dn_Valid),
    .dn_Ready    (dn_Ready),
    .err_CfgZero (err_CfgZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Model: vector v, chunk k covers stream bits
  // v*w + 128k .. +len-1, MSB-aligned, zero padded.
  task automatic build(input int w, input int nvec);
    int nw, nch, len, base, p;
    logic [127:0] tw;
    exp_t e;
    wq.delete();
    exp_q.delete();
    nw  = (nvec * w + 127) / 128;
    nch = (w + 127) / 128;
    for (int i = 0; i < nw; i++)
      wq.push_back({$urandom(), $urandom(),
                    $urandom(), $urandom()});
    for (int v = 0; v < nvec; v++) begin
      for (int k = 0; k < nch; k++) begin
        len  = (w - 128 * k > 128) ? 128 : w - 128 * k;
        base = v * w + 128 * k;
        e.vec = '0;
        for (int j = 0; j < len; j++) begin
          p  = base + j;
          tw = wq[p / 128];
          e.vec[127 - j] = tw[127 - (p % 128)];
        end
        e.id   = v;
        e.sub  = k;
        e.vl   = (k == nch - 1);
        e.last = e.vl && (v == nvec - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_batch(input string nm,
                           input int cfg, input int w,
                           input int nvec, input int vprob,
                           input int rprob, input bit churn,
                           input int stop_after,
                           input bit nobubble);
    int wi, nhs, errs, bubbles, stalls;
    bit done, started;
    exp_t e;
    build(w, nvec);
    wi = 0; nhs = 0; errs = 0;
    bubbles = 0; stalls = 0;
    done = 0; started = 0;
    cfg_VecWidth = 10'(cfg);
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (churn && wi > 0)
        cfg_VecWidth = 10'($urandom_range(1, 920));
      if (err_CfgZero) errs++;
      if (dn_Valid) begin
        started = 1;
        if (exp_q.size() == 0) begin
          chk({nm, " extra_word"}, 128'd1, 128'd0);
          done = 1;
        end else begin
          e = exp_q[0];
          chk({nm, " vec"}, dn_Vector, e.vec);
          chk({nm, " id"}, 128'(dn_VecID), 128'(e.id));
          chk({nm, " sub"}, 128'(dn_SubIdx), 128'(e.sub));
          chk({nm, " veclast"}, 128'(dn_VecLast),
              128'(e.vl));
          chk({nm, " last"}, 128'(dn_Last), 128'(e.last));
        end
      end else if (started) begin
        bubbles++;
      end
      if (wi < wq.size() &&
          $urandom_range(99) < vprob) begin
        up_Valid  = 1'b1;
        up_Vector = wq[wi];
        up_Last   = (wi == wq.size() - 1);
        if (!up_Ready) stalls++;
      end else begin
        up_Valid = 1'b0;
        up_Last  = 1'b0;
      end
      dn_Ready = ($urandom_range(99) < rprob);
      if (up_Valid && up_Ready) wi++;
      if (!done && dn_Valid && dn_Ready &&
          exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nhs++;
        if (e.last) done = 1;
        if (nhs == stop_after) return;
      end
    end
    chk({nm, " completed"}, 128'(done), 128'd1);
    chk({nm, " err_pulses"}, 128'(errs),
        128'((cfg == 0) ? 1 : 0));
    if (nobubble) begin
      chk({nm, " bubbles"}, 128'(bubbles), 128'd0);
      chk({nm, " up_stalls"}, 128'(stalls), 128'd0);
    end
    @(posedge clk);
    #1;
    up_Valid = 1'b0;
    up_Last  = 1'b0;
    dn_Ready = 1'b0;
    chk({nm, " idle_valid"}, 128'(dn_Valid), 128'd0);
    chk({nm, " idle_ready"}, 128'(up_Ready), 128'd1);
  endtask

  initial begin
    int w, nv;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cfg_VecWidth = 10'd920;
    up_Vector = '0;
    up_Valid = 1'b0;
    up_Last = 1'b0;
    dn_Ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst up_Ready", 128'(up_Ready), 128'd1);
    chk("rst dn_Valid", 128'(dn_Valid), 128'd0);
    chk("rst dn_Vector", dn_Vector, 128'd0);
    chk("rst err", 128'(err_CfgZero), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst dn_Valid", 128'(dn_Valid), 128'd0);
    chk("post_rst id", 128'(dn_VecID), 128'd0);

    run_batch("w920x1", 920, 920, 1, 100, 100, 0, 0, 0);
    run_batch("w920x2", 920, 920, 2, 100, 100, 0, 0, 0);
    run_batch("pass128", 128, 128, 10, 100, 100, 0, 0, 1);
    run_batch("stall920", 920, 920, 2, 70, 50, 0, 0, 0);
    run_batch("cfg0", 0, 920, 1, 100, 100, 1, 0, 0);
    run_batch("w64x2", 64, 64, 2, 100, 100, 0, 0, 0);
    run_batch("w100x5", 100, 100, 5, 80, 60, 0, 0, 0);

    run_batch("abort", 920, 920, 2, 100, 100, 0, 3, 0);
    @(posedge clk);
    #1;
    dn_Ready = 1'b0;
    up_Valid = 1'b0;
    up_Last  = 1'b0;
    @(negedge clk);
    chk("abort pre_valid", 128'(dn_Valid), 128'd1);
    chk("abort pre_sub", 128'(dn_SubIdx), 128'd3);
    #1 rst = 1'b1;
    #1;
    chk("abort async_valid", 128'(dn_Valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort up_Ready", 128'(up_Ready), 128'd1);
    chk("abort id", 128'(dn_VecID), 128'd0);
    chk("abort sub", 128'(dn_SubIdx), 128'd0);
    run_batch("after_rst", 300, 300, 3, 90, 70, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      w  = $urandom_range(128, 920);
      nv = $urandom_range(1, 3);
      run_batch($sformatf("rand%0d", r), w, w, nv,
                $urandom_range(50, 100),
                $urandom_range(40, 100), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
